// File: rtl/mvm_pkg.sv
//==============================================================================
// Module      : mvm_pkg
// Description : Shared types and default widths for the MVM engine controllers.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package mvm_pkg;

    localparam int VEC_ADDRW_DEF  = 8;
    localparam int MAT_ADDRW_DEF  = 9;
    localparam int NUM_OLANES_DEF = 8;
    localparam int DATAW_DEF      = 64;

    typedef enum logic {
        DEST_VEC = 1'b0,
        DEST_MAT = 1'b1
    } dest_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } wr_state_e;

endpackage

`default_nettype wire

// File: rtl/mvm_write_ctrl.sv
//==============================================================================
// Module      : mvm_write_ctrl
// Description : Streams command-sized bursts of words into the vector memory or
//               one output lane's matrix memory, one word per cycle peak.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mvm_write_ctrl
    import mvm_pkg::*;
#(
    parameter int VEC_ADDRW  = VEC_ADDRW_DEF,
    parameter int MAT_ADDRW  = MAT_ADDRW_DEF,
    parameter int NUM_OLANES = NUM_OLANES_DEF,
    parameter int DATAW      = DATAW_DEF,
    parameter int LANEW      = $clog2(NUM_OLANES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_dest,
    input  logic [LANEW-1:0]      cmd_lane,
    input  logic [MAT_ADDRW-1:0]  cmd_start_addr,
    input  logic [MAT_ADDRW:0]    cmd_num_words,
    input  logic [DATAW-1:0]      idata,
    input  logic                  ivalid,
    output logic                  iready,
    input  logic                  mvm_busy,
    output logic [DATAW-1:0]      vec_wdata,
    output logic [VEC_ADDRW-1:0]  vec_waddr,
    output logic                  vec_wen,
    output logic [DATAW-1:0]      mat_wdata,
    output logic [MAT_ADDRW-1:0]  mat_waddr,
    output logic [NUM_OLANES-1:0] mat_wen,
    output logic                  busy,
    output logic                  done
);

    localparam logic [MAT_ADDRW:0]   c_rem_zero = '0;
    localparam logic [MAT_ADDRW:0]   c_rem_one  = {{MAT_ADDRW{1'b0}}, 1'b1};
    localparam logic [MAT_ADDRW-1:0] c_addr_one = {{(MAT_ADDRW-1){1'b0}}, 1'b1};

    wr_state_e             state_q,   state_d;
    dest_e                 dest_q,    dest_d;
    logic [LANEW-1:0]      lane_q,    lane_d;
    logic [MAT_ADDRW-1:0]  addr_q,    addr_d;
    logic [MAT_ADDRW:0]    rem_q,     rem_d;
    logic [MAT_ADDRW-1:0]  waddr_q,   waddr_d;
    logic [DATAW-1:0]      wdata_q,   wdata_d;
    logic                  vec_wen_q, vec_wen_d;
    logic [NUM_OLANES-1:0] mat_wen_q, mat_wen_d;
    logic                  busy_q,    busy_d;
    logic                  done_q,    done_d;

    logic w_cmd_hs;
    logic w_data_hs;

    // Both ready signals fall the moment the compute side claims the memories.
    assign cmd_ready = (state_q == ST_IDLE) && !mvm_busy;
    assign iready    = (state_q == ST_LOAD) && !mvm_busy;
    assign w_cmd_hs  = cmd_valid && cmd_ready;
    assign w_data_hs = ivalid && iready;

    always_comb begin
        state_d   = state_q;
        dest_d    = dest_q;
        lane_d    = lane_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        vec_wen_d = 1'b0;
        mat_wen_d = '0;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_cmd_hs) begin
                    dest_d = dest_e'(cmd_dest);
                    lane_d = cmd_lane;
                    addr_d = cmd_start_addr;
                    rem_d  = cmd_num_words;
                    if (cmd_num_words == c_rem_zero) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (w_data_hs) begin
                    waddr_d = addr_q;
                    wdata_d = idata;
                    if (dest_q == DEST_VEC) begin
                        vec_wen_d = 1'b1;
                    end else begin
                        mat_wen_d[lane_q] = 1'b1;
                    end
                    // Counter wraps naturally; the vector port only sees the low bits.
                    addr_d = addr_q + c_addr_one;
                    rem_d  = rem_q - c_rem_one;
                    if (rem_q == c_rem_one) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Busy covers the registered final write, which lands after leaving LOAD.
        busy_d = (state_d == ST_LOAD) || ((state_q == ST_LOAD) && done_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            dest_q    <= DEST_VEC;
            lane_q    <= '0;
            addr_q    <= '0;
            rem_q     <= '0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            vec_wen_q <= 1'b0;
            mat_wen_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dest_q    <= dest_d;
            lane_q    <= lane_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            vec_wen_q <= vec_wen_d;
            mat_wen_q <= mat_wen_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign vec_wdata = wdata_q;
    assign vec_waddr = waddr_q[VEC_ADDRW-1:0];
    assign vec_wen   = vec_wen_q;
    assign mat_wdata = wdata_q;
    assign mat_waddr = waddr_q;
    assign mat_wen   = mat_wen_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_mvm_write_ctrl.sv
//==============================================================================
// Module      : tb_mvm_write_ctrl
// Description : Cycle-by-cycle directed vectors for mvm_write_ctrl.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mvm_write_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_dest = 1'b0;
    logic [2:0]  cmd_lane = '0;
    logic [8:0]  cmd_start_addr = '0;
    logic [9:0]  cmd_num_words = '0;
    logic [63:0] idata = '0;
    logic        ivalid = 1'b0;
    logic        iready;
    logic        mvm_busy = 1'b0;
    logic [63:0] vec_wdata;
    logic [7:0]  vec_waddr;
    logic        vec_wen;
    logic [63:0] mat_wdata;
    logic [8:0]  mat_waddr;
    logic [7:0]  mat_wen;
    logic        busy;
    logic        done;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mvm_write_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_dest       (cmd_dest),
        .cmd_lane       (cmd_lane),
        .cmd_start_addr (cmd_start_addr),
        .cmd_num_words  (cmd_num_words),
        .idata          (idata),
        .ivalid         (ivalid),
        .iready         (iready),
        .mvm_busy       (mvm_busy),
        .vec_wdata      (vec_wdata),
        .vec_waddr      (vec_waddr),
        .vec_wen        (vec_wen),
        .mat_wdata      (mat_wdata),
        .mat_waddr      (mat_waddr),
        .mat_wen        (mat_wen),
        .busy           (busy),
        .done           (done)
    );

    typedef struct {
        logic        cv;
        logic        dest;
        logic [2:0]  lane;
        logic [8:0]  start;
        logic [9:0]  num;
        logic        iv;
        logic [63:0] d;
        logic        mb;
        logic        e_cr;
        logic        e_ir;
        logic        e_vw;
        logic [7:0]  e_mw;
        logic [8:0]  e_a;
        logic [63:0] e_d;
        logic        e_busy;
        logic        e_done;
    } vec_t;

    vec_t tbl_a[$];
    vec_t tbl_b[$];

    function automatic logic [63:0] dat(input int n);
        logic [31:0] k;
        k = n[31:0];
        return {32'hD00D_0000 | k, ~k};
    endfunction

    function automatic vec_t mk(
        input logic cv, input logic dest, input logic [2:0] lane, input logic [8:0] start,
        input logic [9:0] num, input logic iv, input logic [63:0] d, input logic mb,
        input logic e_cr, input logic e_ir, input logic e_vw, input logic [7:0] e_mw,
        input logic [8:0] e_a, input logic [63:0] e_d, input logic e_busy, input logic e_done);
        vec_t v;
        v.cv = cv; v.dest = dest; v.lane = lane; v.start = start; v.num = num;
        v.iv = iv; v.d = d; v.mb = mb;
        v.e_cr = e_cr; v.e_ir = e_ir; v.e_vw = e_vw; v.e_mw = e_mw;
        v.e_a = e_a; v.e_d = e_d; v.e_busy = e_busy; v.e_done = e_done;
        return v;
    endfunction

    // Inputs change at negedge; outputs are checked 1 time unit later.
    task automatic apply(input vec_t v, input int idx);
        logic bad;
        @(negedge clk);
        cmd_valid = v.cv; cmd_dest = v.dest; cmd_lane = v.lane;
        cmd_start_addr = v.start; cmd_num_words = v.num;
        ivalid = v.iv; idata = v.d; mvm_busy = v.mb;
        #1;
        bad = (cmd_ready !== v.e_cr) || (iready !== v.e_ir) || (vec_wen !== v.e_vw) ||
              (mat_wen !== v.e_mw) || (busy !== v.e_busy) || (done !== v.e_done);
        if (v.e_vw)
            bad = bad || (vec_waddr !== v.e_a[7:0]) || (vec_wdata !== v.e_d);
        if (v.e_mw != 8'h00)
            bad = bad || (mat_waddr !== v.e_a) || (mat_wdata !== v.e_d);
        n_vec++;
        if (bad) begin
            n_bad++;
            $display("FAIL vec%0d: got cr=%b ir=%b vw=%b mw=%h va=%h ma=%h vd=%h busy=%b done=%b; want cr=%b ir=%b vw=%b mw=%h a=%h d=%h busy=%b done=%b",
                     idx, cmd_ready, iready, vec_wen, mat_wen, vec_waddr, mat_waddr, vec_wdata,
                     busy, done, v.e_cr, v.e_ir, v.e_vw, v.e_mw, v.e_a, v.e_d, v.e_busy, v.e_done);
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    initial begin
        // Vector load: dest 0, start 10, 4 words back to back
        tbl_a.push_back(mk(1,0,0,10,4, 0,0,0,       1,0,0,8'h00,0,0,0,0));
        tbl_a.push_back(mk(0,0,0,0,0,  1,dat(0),0,  0,1,0,8'h00,0,0,1,0));
        tbl_a.push_back(mk(0,0,0,0,0,  1,dat(1),0,  0,1,1,8'h00,10,dat(0),1,0));
        tbl_a.push_back(mk(0,0,0,0,0,  1,dat(2),0,  0,1,1,8'h00,11,dat(1),1,0));
        tbl_a.push_back(mk(0,0,0,0,0,  1,dat(3),0,  0,1,1,8'h00,12,dat(2),1,0));
        tbl_a.push_back(mk(0,0,0,0,0,  0,0,0,       1,0,1,8'h00,13,dat(3),1,1));
        tbl_a.push_back(mk(0,0,0,0,0,  0,0,0,       1,0,0,8'h00,0,0,0,0));
        // Matrix lane 5, start 508, 6 words with ivalid gaps, address wraps
        tbl_a.push_back(mk(1,1,5,508,6, 0,0,0,      1,0,0,8'h00,0,0,0,0));
        tbl_a.push_back(mk(0,0,0,0,0,  1,dat(10),0, 0,1,0,8'h00,0,0,1,0));
        tbl_a.push_back(mk(0,0,0,0,0,  0,0,0,       0,1,0,8'h20,508,dat(10),1,0));
        tbl_a.push_back(mk(0,0,0,0,0,  1,dat(11),0, 0,1,0,8'h00,0,0,1,0));
        tbl_a.push_back(mk(0,0,0,0,0,  1,dat(12),0, 0,1,0,8'h20,509,dat(11),1,0));
        tbl_a.push_back(mk(0,0,0,0,0,  0,0,0,       0,1,0,8'h20,510,dat(12),1,0));
        tbl_a.push_back(mk(0,0,0,0,0,  0,0,0,       0,1,0,8'h00,0,0,1,0));
        tbl_a.push_back(mk(0,0,0,0,0,  1,dat(13),0, 0,1,0,8'h00,0,0,1,0));
        tbl_a.push_back(mk(0,0,0,0,0,  1,dat(14),0, 0,1,0,8'h20,511,dat(13),1,0));
        tbl_a.push_back(mk(0,0,0,0,0,  1,dat(15),0, 0,1,0,8'h20,0,dat(14),1,0));
        tbl_a.push_back(mk(0,0,0,0,0,  0,0,0,       1,0,0,8'h20,1,dat(15),1,1));
        tbl_a.push_back(mk(0,0,0,0,0,  0,0,0,       1,0,0,8'h00,0,0,0,0));
        // Zero-count command: done one cycle later, no write, no busy
        tbl_a.push_back(mk(1,0,0,3,0,  0,0,0,       1,0,0,8'h00,0,0,0,0));
        tbl_a.push_back(mk(0,0,0,0,0,  1,dat(99),0, 1,0,0,8'h00,0,0,0,1));
        tbl_a.push_back(mk(0,0,0,0,0,  0,0,0,       1,0,0,8'h00,0,0,0,0));
        // mvm_busy blocks accept, then stalls the stream for 3 cycles
        tbl_a.push_back(mk(1,1,2,100,8, 0,0,1,      0,0,0,8'h00,0,0,0,0));
        tbl_a.push_back(mk(1,1,2,100,8, 0,0,0,      1,0,0,8'h00,0,0,0,0));
        tbl_a.push_back(mk(0,0,0,0,0,  1,dat(20),0, 0,1,0,8'h00,0,0,1,0));
        tbl_a.push_back(mk(0,0,0,0,0,  1,dat(21),0, 0,1,0,8'h04,100,dat(20),1,0));
        tbl_a.push_back(mk(0,0,0,0,0,  1,dat(22),1, 0,0,0,8'h04,101,dat(21),1,0));
        tbl_a.push_back(mk(0,0,0,0,0,  1,dat(22),1, 0,0,0,8'h00,0,0,1,0));
        tbl_a.push_back(mk(0,0,0,0,0,  1,dat(22),1, 0,0,0,8'h00,0,0,1,0));
        tbl_a.push_back(mk(0,0,0,0,0,  1,dat(22),0, 0,1,0,8'h00,0,0,1,0));
        tbl_a.push_back(mk(0,0,0,0,0,  1,dat(23),0, 0,1,0,8'h04,102,dat(22),1,0));
        tbl_a.push_back(mk(0,0,0,0,0,  1,dat(24),0, 0,1,0,8'h04,103,dat(23),1,0));
        tbl_a.push_back(mk(0,0,0,0,0,  1,dat(25),0, 0,1,0,8'h04,104,dat(24),1,0));
        tbl_a.push_back(mk(0,0,0,0,0,  1,dat(26),0, 0,1,0,8'h04,105,dat(25),1,0));
        tbl_a.push_back(mk(0,0,0,0,0,  1,dat(27),0, 0,1,0,8'h04,106,dat(26),1,0));
        tbl_a.push_back(mk(0,0,0,0,0,  0,0,0,       1,0,0,8'h04,107,dat(27),1,1));
        tbl_a.push_back(mk(0,0,0,0,0,  0,0,0,       1,0,0,8'h00,0,0,0,0));
        // Back-to-back: lane 0 then lane 7, second accepted in the done cycle
        tbl_a.push_back(mk(1,1,0,40,2,  0,0,0,      1,0,0,8'h00,0,0,0,0));
        tbl_a.push_back(mk(0,0,0,0,0,  1,dat(30),0, 0,1,0,8'h00,0,0,1,0));
        tbl_a.push_back(mk(0,0,0,0,0,  1,dat(31),0, 0,1,0,8'h01,40,dat(30),1,0));
        tbl_a.push_back(mk(1,1,7,300,3, 1,dat(40),0, 1,0,0,8'h01,41,dat(31),1,1));
        tbl_a.push_back(mk(0,0,0,0,0,  1,dat(40),0, 0,1,0,8'h00,0,0,1,0));
        tbl_a.push_back(mk(0,0,0,0,0,  1,dat(41),0, 0,1,0,8'h80,300,dat(40),1,0));
        tbl_a.push_back(mk(0,0,0,0,0,  1,dat(42),0, 0,1,0,8'h80,301,dat(41),1,0));
        tbl_a.push_back(mk(0,0,0,0,0,  0,0,0,       1,0,0,8'h80,302,dat(42),1,1));
        tbl_a.push_back(mk(0,0,0,0,0,  0,0,0,       1,0,0,8'h00,0,0,0,0));
        // Start of a 10-word vector load that gets reset after 3 words
        tbl_a.push_back(mk(1,0,0,250,10, 0,0,0,     1,0,0,8'h00,0,0,0,0));
        tbl_a.push_back(mk(0,0,0,0,0,  1,dat(50),0, 0,1,0,8'h00,0,0,1,0));
        tbl_a.push_back(mk(0,0,0,0,0,  1,dat(51),0, 0,1,1,8'h00,250,dat(50),1,0));
        tbl_a.push_back(mk(0,0,0,0,0,  1,dat(52),0, 0,1,1,8'h00,251,dat(51),1,0));
        tbl_a.push_back(mk(0,0,0,0,0,  0,0,0,       0,1,1,8'h00,252,dat(52),1,0));
        // Fresh single-word command after reset
        tbl_b.push_back(mk(0,0,0,0,0,  1,dat(55),0, 1,0,0,8'h00,0,0,0,0));
        tbl_b.push_back(mk(1,1,3,7,1,  0,0,0,       1,0,0,8'h00,0,0,0,0));
        tbl_b.push_back(mk(0,0,0,0,0,  1,dat(60),0, 0,1,0,8'h00,0,0,1,0));
        tbl_b.push_back(mk(0,0,0,0,0,  0,0,0,       1,0,0,8'h08,7,dat(60),1,1));
        tbl_b.push_back(mk(0,0,0,0,0,  0,0,0,       1,0,0,8'h00,0,0,0,0));

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_iready",    64'(iready),    64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_done",      64'(done),      64'd0);
        chk("rst_vec_wen",   64'(vec_wen),   64'd0);
        chk("rst_mat_wen",   64'(mat_wen),   64'd0);
        chk("rst_addr",      64'({vec_waddr, mat_waddr}), 64'd0);
        chk("rst_data",      vec_wdata | mat_wdata, 64'd0);
        mvm_busy = 1'b1;
        #1;
        chk("rst_cmd_ready_mvm_busy", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        mvm_busy = 1'b0;

        for (int i = 0; i < tbl_a.size(); i++)
            apply(tbl_a[i], i);

        // Asynchronous reset mid-LOAD, while the 3rd word's write is showing
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_vec_wen", 64'(vec_wen), 64'd0);
        chk("mid_rst_mat_wen", 64'(mat_wen), 64'd0);
        chk("mid_rst_busy",    64'(busy),    64'd0);
        chk("mid_rst_done",    64'(done),    64'd0);
        chk("mid_rst_iready",  64'(iready),  64'd0);
        chk("mid_rst_addr",    64'(vec_waddr), 64'd0);
        @(negedge clk);
        #1;
        chk("mid_rst_no_done", 64'({busy, done, vec_wen}), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < tbl_b.size(); i++)
            apply(tbl_b[i], 1000 + i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
